// File: rtl/v_lane_mem_ctrl.sv
// Memory-side controller for one vector lane: streams cmd_len elements between a
// single-ported data memory and the lane load FIFO (loads) or store FIFO (stores).
module v_lane_mem_ctrl #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned VECTOR_LENGTH = 1024,
  parameter int unsigned ADDR_WIDTH    = 32
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          cmd_valid_i,
  output logic                                          cmd_ready_o,
  input  logic                                          cmd_store_i,
  input  logic [ADDR_WIDTH-1:0]                         cmd_base_addr_i,
  input  logic [$clog2(VECTOR_LENGTH/DATA_WIDTH):0]     cmd_len_i,
  output logic [ADDR_WIDTH-1:0]                         mem_addr_o,
  output logic                                          mem_re_o,
  input  logic [DATA_WIDTH-1:0]                         mem_rdata_i,
  output logic                                          mem_we_o,
  output logic [DATA_WIDTH-1:0]                         mem_wdata_o,
  output logic                                          load_fifo_we_o,
  output logic [DATA_WIDTH-1:0]                         data_to_lane_o,
  input  logic                                          load_fifo_almostfull_i,
  input  logic                                          load_fifo_full_i,
  output logic                                          store_fifo_re_o,
  input  logic [DATA_WIDTH-1:0]                         data_from_lane_i,
  input  logic                                          store_fifo_empty_i,
  output logic                                          done_o,
  output logic                                          busy_o
);

  localparam int unsigned MAX_EL = VECTOR_LENGTH / DATA_WIDTH;
  localparam int unsigned LEN_W  = $clog2(MAX_EL) + 1;
  localparam int unsigned BYTES  = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_DRAIN,
    S_STORE,
    S_STORE_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_W-1:0]      remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  st_pend_q, st_pend_d;
  logic [LEN_W-1:0]      len_clamped;
  logic                  rd_issue, st_issue, wr_issue, ld_write;

  always_comb begin
    len_clamped = (cmd_len_i > LEN_W'(MAX_EL)) ? LEN_W'(MAX_EL) : cmd_len_i;
  end

  // State, element counter and address counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      addr_q      <= '0;
      last_addr_q <= '0;
      rd_pend_q   <= 1'b0;
      st_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      rd_pend_q   <= rd_pend_d;
      st_pend_q   <= st_pend_d;
    end
  end

  // Next-state and strobe generation.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    rd_pend_d   = 1'b0;
    st_pend_d   = 1'b0;
    rd_issue    = 1'b0;
    st_issue    = 1'b0;
    wr_issue    = st_pend_q;
    // Full only asserts if the lane's almost-full threshold is wrong; never overrun it.
    ld_write    = rd_pend_q & ~load_fifo_full_i;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          addr_d      = cmd_base_addr_i;
          remaining_d = len_clamped;
          if (len_clamped == '0)   state_d = S_DONE;
          else if (cmd_store_i)    state_d = S_STORE;
          else                     state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if ((remaining_q != '0) && !load_fifo_almostfull_i) begin
          rd_issue    = 1'b1;
          rd_pend_d   = 1'b1;
          addr_d      = addr_q + ADDR_WIDTH'(BYTES);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = S_LOAD_DRAIN;
        end
      end
      S_LOAD_DRAIN: state_d = S_DONE;
      S_STORE: begin
        if (wr_issue) addr_d = addr_q + ADDR_WIDTH'(BYTES);
        if ((remaining_q != '0) && !store_fifo_empty_i) begin
          st_issue    = 1'b1;
          st_pend_d   = 1'b1;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = S_STORE_DRAIN;
        end
      end
      S_STORE_DRAIN: begin
        if (wr_issue) addr_d = addr_q + ADDR_WIDTH'(BYTES);
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (rd_issue || wr_issue) last_addr_d = addr_q;
  end

  // The address bus holds its last driven value between strobes.
  always_comb begin
    mem_re_o        = rd_issue;
    mem_we_o        = wr_issue;
    mem_addr_o      = (rd_issue || wr_issue) ? addr_q : last_addr_q;
    mem_wdata_o     = wr_issue ? data_from_lane_i : '0;
    load_fifo_we_o  = ld_write;
    data_to_lane_o  = ld_write ? mem_rdata_i : '0;
    store_fifo_re_o = st_issue;
    done_o          = (state_q == S_DONE);
    busy_o          = (state_q != S_IDLE);
    cmd_ready_o     = (state_q == S_IDLE);
  end

endmodule

// File: tb/tb_v_lane_mem_ctrl.sv
// Scoreboard bench for v_lane_mem_ctrl: commands push expected memory/FIFO traffic,
// a negedge monitor pops and compares whenever the controller strobes.
module tb_v_lane_mem_ctrl;

  localparam int LF_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_store;
  logic [31:0] cmd_base;
  logic [5:0]  cmd_len;
  logic        cmd_ready_o;
  logic [31:0] mem_addr_o, mem_wdata_o, data_to_lane_o;
  logic        mem_re_o, mem_we_o, load_fifo_we_o, store_fifo_re_o, done_o, busy_o;
  logic [31:0] mem_rdata_i, data_from_lane_i;
  logic        load_fifo_almostfull_i, load_fifo_full_i, store_fifo_empty_i;

  v_lane_mem_ctrl dut (
    .clk                    (clk),
    .reset                  (reset),
    .cmd_valid_i            (cmd_valid),
    .cmd_ready_o            (cmd_ready_o),
    .cmd_store_i            (cmd_store),
    .cmd_base_addr_i        (cmd_base),
    .cmd_len_i              (cmd_len),
    .mem_addr_o             (mem_addr_o),
    .mem_re_o               (mem_re_o),
    .mem_rdata_i            (mem_rdata_i),
    .mem_we_o               (mem_we_o),
    .mem_wdata_o            (mem_wdata_o),
    .load_fifo_we_o         (load_fifo_we_o),
    .data_to_lane_o         (data_to_lane_o),
    .load_fifo_almostfull_i (load_fifo_almostfull_i),
    .load_fifo_full_i       (load_fifo_full_i),
    .store_fifo_re_o        (store_fifo_re_o),
    .data_from_lane_i       (data_from_lane_i),
    .store_fifo_empty_i     (store_fifo_empty_i),
    .done_o                 (done_o),
    .busy_o                 (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc;
    int delta;
    bit timed;
  } done_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lf_cnt   = 0;
  int          re_count = 0;
  bit          prev_re  = 1'b0;
  bit          prev_sre = 1'b0;
  bit          af_force = 1'b0;
  bit          lf_rand  = 1'b0;
  bit          tog      = 1'b0;
  int          empty_mode = 0;
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] lane_q[$];
  logic [31:0] store_data_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_ld_q[$];
  logic [63:0] exp_wr_q[$];
  done_t       done_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Lane load FIFO occupancy model and memory / store-FIFO responders.
  assign load_fifo_full_i       = (lf_cnt >= LF_DEPTH);
  assign load_fifo_almostfull_i = af_force || ((LF_DEPTH - lf_cnt) <= 2);

  always @(posedge clk) begin
    bit drain;
    cyc <= cyc + 1;
    drain = lf_rand ? ($urandom_range(2) == 0) : 1'b1;
    lf_cnt <= lf_cnt + (load_fifo_we_o ? 1 : 0) - ((drain && lf_cnt > 0) ? 1 : 0);
    if (mem_re_o) mem_rdata_i <= mem_val(mem_addr_o);
    else          mem_rdata_i <= $urandom;
    if (store_fifo_re_o && lane_q.size() != 0) data_from_lane_i <= lane_q.pop_front();
    else                                       data_from_lane_i <= $urandom;
  end

  always @(posedge clk) begin
    #1;
    tog = ~tog;
    store_fifo_empty_i = (lane_q.size() == 0) || (empty_mode == 1 && tog) ||
                         (empty_mode == 2 && $urandom_range(1) == 1);
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_re_o || mem_we_o) chk("mutex", 64'(mem_re_o & mem_we_o), 64'd0);
    if (mem_re_o) begin
      chk("rd_expected", 64'(exp_rd_q.size() != 0), 64'd1);
      if (exp_rd_q.size() != 0) chk("rd_addr", 64'(mem_addr_o), 64'(exp_rd_q.pop_front()));
    end
    if (load_fifo_we_o) begin
      chk("ld_latency", 64'(prev_re), 64'd1);
      chk("ld_fifo_full", 64'(load_fifo_full_i), 64'd0);
      chk("ld_expected", 64'(exp_ld_q.size() != 0), 64'd1);
      if (exp_ld_q.size() != 0) chk("ld_data", 64'(data_to_lane_o), 64'(exp_ld_q.pop_front()));
    end
    if (mem_we_o) begin
      logic [63:0] e;
      chk("wr_latency", 64'(prev_sre), 64'd1);
      chk("wr_expected", 64'(exp_wr_q.size() != 0), 64'd1);
      if (exp_wr_q.size() != 0) begin
        e = exp_wr_q.pop_front();
        chk("wr_addr", 64'(mem_addr_o), 64'(e[63:32]));
        chk("wr_data", 64'(mem_wdata_o), 64'(e[31:0]));
      end
    end
    if (done_o) begin
      done_t d;
      chk("done_expected", 64'(done_q.size() != 0), 64'd1);
      if (done_q.size() != 0) begin
        d = done_q.pop_front();
        if (d.timed) chk("done_cycle", 64'(cyc - d.acc), 64'(d.delta));
      end
    end
    prev_re  = mem_re_o;
    prev_sre = store_fifo_re_o;
    if (mem_re_o) re_count++;
  end

  task automatic issue(input bit st, input logic [31:0] base, input int len,
                       input bit timed, input bit push_exp);
    int n, c;
    logic [31:0] a, d;
    n = (len > 32) ? 32 : len;
    if (push_exp) begin
      for (int i = 0; i < n; i++) begin
        a = base + 32'(4 * i);
        if (st) begin
          d = (store_data_q.size() != 0) ? store_data_q.pop_front() : $urandom;
          lane_q.push_back(d);
          exp_wr_q.push_back({a, d});
          mem_model[a] = d;
        end else begin
          exp_rd_q.push_back(a);
          exp_ld_q.push_back(mem_val(a));
        end
      end
    end
    @(negedge clk);
    chk("cmd_ready_idle", 64'(cmd_ready_o), 64'd1);
    cmd_valid = 1'b1;
    cmd_store = st;
    cmd_base  = base;
    cmd_len   = 6'(len);
    c = cyc;
    @(posedge clk);
    if (push_exp) done_q.push_back('{acc: c + 1, delta: (n == 0) ? 0 : n + 1, timed: timed});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while ((done_q.size() != 0 || !cmd_ready_o) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({"completes_", tag}, 64'(k < 400), 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_reads(input int n);
    int k = 0;
    while (re_count < n && k < 100) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk("read_count_reached", 64'(re_count >= n), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_store = 1'b0;
    cmd_base = '0;
    cmd_len = '0;
    store_fifo_empty_i = 1'b1;
    mem_rdata_i = '0;
    data_from_lane_i = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_ready", 64'(cmd_ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_strobes", 64'({mem_re_o, mem_we_o, load_fifo_we_o, store_fifo_re_o}), 64'd0);
    chk("rst_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_data", 64'({mem_wdata_o, data_to_lane_o}), 64'd0);

    // Unstalled load with known memory contents.
    for (int i = 0; i < 4; i++) mem_model[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
    issue(1'b0, 32'h100, 4, 1'b1, 1'b1);
    wait_done("load4");

    // Load with almost-full held for 3 cycles after the 2nd read.
    re_count = 0;
    issue(1'b0, 32'h1000, 8, 1'b0, 1'b1);
    wait_reads(2);
    @(posedge clk);
    #1 af_force = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_no_read", 64'(mem_re_o), 64'd0);
    end
    @(posedge clk);
    #1 af_force = 1'b0;
    wait_done("load_stall");

    // Store with store FIFO empty toggling.
    store_data_q = '{32'h11, 32'h22, 32'h33};
    empty_mode = 1;
    issue(1'b1, 32'h200, 3, 1'b0, 1'b1);
    wait_done("store_gaps");
    empty_mode = 0;

    // Zero length, clamping, unstalled store, address wrap.
    issue(1'b0, 32'h500, 0, 1'b1, 1'b1);
    wait_done("len0_load");
    issue(1'b1, 32'h600, 0, 1'b1, 1'b1);
    wait_done("len0_store");
    issue(1'b0, 32'h2000, 40, 1'b1, 1'b1);
    wait_done("load_clamp");
    issue(1'b1, 32'h3000, 40, 1'b1, 1'b1);
    wait_done("store_clamp");
    issue(1'b0, 32'h3004, 5, 1'b1, 1'b1);
    wait_done("load_after_store");
    issue(1'b0, 32'hFFFF_FFF8, 4, 1'b1, 1'b1);
    wait_done("wrap");

    // Command presented while busy must be ignored.
    issue(1'b0, 32'h400, 6, 1'b1, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_store = 1'b1;
    cmd_base  = 32'h999;
    cmd_len   = 6'd5;
    chk("busy_not_ready", 64'(cmd_ready_o), 64'd0);
    chk("busy_flag", 64'(busy_o), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done("busy_ignore");

    // Reset during the 3rd read of a len-8 load.
    re_count = 0;
    for (int i = 0; i < 3; i++) exp_rd_q.push_back(32'h300 + 32'(4 * i));
    for (int i = 0; i < 2; i++) exp_ld_q.push_back(mem_val(32'h300 + 32'(4 * i)));
    issue(1'b0, 32'h300, 8, 1'b0, 1'b0);
    wait_reads(3);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 64'(cmd_ready_o), 64'd1);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_strobes", 64'({mem_re_o, mem_we_o, load_fifo_we_o, store_fifo_re_o, done_o}), 64'd0);
    chk("midrst_addr", 64'(mem_addr_o), 64'd0);
    chk("midrst_data", 64'({mem_wdata_o, data_to_lane_o}), 64'd0);
    repeat (5) @(negedge clk);
    chk("midrst_no_extra_ld", 64'(exp_ld_q.size()), 64'd0);
    chk("midrst_reads_done", 64'(exp_rd_q.size()), 64'd0);

    // Randomized commands with random FIFO backpressure.
    lf_rand = 1'b1;
    empty_mode = 2;
    for (int i = 0; i < 25; i++) begin
      issue(1'($urandom_range(1)), $urandom & 32'hFFFF_FFFC, int'($urandom_range(40)), 1'b0, 1'b1);
      wait_done("random");
    end
    lf_rand = 1'b0;
    empty_mode = 0;

    repeat (5) @(negedge clk);
    chk("left_rd", 64'(exp_rd_q.size()), 64'd0);
    chk("left_ld", 64'(exp_ld_q.size()), 64'd0);
    chk("left_wr", 64'(exp_wr_q.size()), 64'd0);
    chk("left_done", 64'(done_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/v_lane_mem_ctrl.md
# v_lane_mem_ctrl

Memory-side controller for one vector lane. It moves a vector of `cmd_len_i` elements between a single-ported data memory and the lane's load FIFO (for vector loads) or store FIFO (for vector stores). It drives the lane's `load_fifo_we_i`, `data_from_mem_i` and `store_fifo_re_i`, and consumes the lane's FIFO status and `data_to_mem_o`. It sits between the vector memory arbiter and the lane.

## Interface
Parameters:
- `DATA_WIDTH`, 32: element and memory word width.
- `VECTOR_LENGTH`, 1024: vector register size in bits. The maximum element count is `MAX_EL = VECTOR_LENGTH/DATA_WIDTH`, which is 32 at the defaults.
- `ADDR_WIDTH`, 32: memory byte-address width.

Ports (all synchronous to `clk`):
- `clk`  in  1  single clock. Everything is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid_i`  in  1  a command is presented.
- `cmd_ready_o`  out  1  the controller is idle and can accept a command.
- `cmd_store_i`  in  1  0 = load (memory to lane), 1 = store (lane to memory).
- `cmd_base_addr_i`  in  ADDR_WIDTH  byte address of element 0.
- `cmd_len_i`  in  $clog2(MAX_EL)+1  element count.
- `mem_addr_o`  out  ADDR_WIDTH  memory byte address.
- `mem_re_o`  out  1  memory read strobe. Read data returns 1 cycle later.
- `mem_rdata_i`  in  DATA_WIDTH  memory read data.
- `mem_we_o`  out  1  memory write strobe.
- `mem_wdata_o`  out  DATA_WIDTH  memory write data.
- `load_fifo_we_o`  out  1  write into the lane load FIFO. Connects to the lane's `load_fifo_we_i`.
- `data_to_lane_o`  out  DATA_WIDTH  load FIFO write data. Connects to the lane's `data_from_mem_i`.
- `load_fifo_almostfull_i`  in  1  lane load FIFO has 2 or fewer free entries.
- `load_fifo_full_i`  in  1  lane load FIFO is full.
- `store_fifo_re_o`  out  1  read from the lane store FIFO. Connects to the lane's `store_fifo_re_i`.
- `data_from_lane_i`  in  DATA_WIDTH  lane `data_to_mem_o`. Valid 1 cycle after `store_fifo_re_o`.
- `store_fifo_empty_i`  in  1  lane store FIFO is empty.
- `done_o`  out  1  one-cycle pulse when the command completes.
- `busy_o`  out  1  the controller is not idle.

## Operation
- **FSM states:** IDLE, LOAD, LOAD_DRAIN, STORE, STORE_DRAIN, DONE.
- **IDLE:**
  - `cmd_ready_o`=1.
  - On `cmd_valid_i` & `cmd_ready_o`, the controller latches the base address into the address counter.
  - It latches the length as `min(cmd_len_i, MAX_EL)` into `remaining`.
  - Next state: DONE if the length is 0, else LOAD or STORE according to `cmd_store_i`.
- **LOAD:**
  - Each cycle with `remaining`>0 and `load_fifo_almostfull_i`=0, the controller asserts `mem_re_o` and drives `mem_addr_o` = address counter.
  - It then advances the address counter by DATA_WIDTH/8 and decrements `remaining`.
  - One cycle after each `mem_re_o`, it asserts `load_fifo_we_o` with `data_to_lane_o` = `mem_rdata_i`, unregistered pass-through of the returning word.
  - When the last read is issued, the next state is LOAD_DRAIN.
- **LOAD_DRAIN:**
  - The final `load_fifo_we_o` occurs in this state.
  - Next state is DONE.
- **STORE:**
  - Each cycle with `remaining`>0 and `store_fifo_empty_i`=0, the controller asserts `store_fifo_re_o` and decrements `remaining`.
  - One cycle later it asserts `mem_we_o` with `mem_wdata_o` = `data_from_lane_i` and `mem_addr_o` = address counter, then advances the address counter.
  - When the last read is issued, the next state is STORE_DRAIN.
- **STORE_DRAIN:**
  - The final `mem_we_o` occurs in this state.
  - Next state is DONE.
- **DONE:**
  - `done_o`=1 for one cycle.
  - Next state is IDLE.
- **Mutual exclusion:** `mem_re_o` and `mem_we_o` are never both 1.
- **Backpressure:**
  - The controller never writes the load FIFO while `load_fifo_full_i`=1.
  - The almost-full gating guarantees this with at most one read in flight.
- **Address arithmetic:**
  - Increments are modulo 2^ADDR_WIDTH; wrap-around is silent.
  - `mem_addr_o` holds its last value when no strobe is active.
- **Commands while busy:** `cmd_valid_i` in any state other than IDLE is ignored (`cmd_ready_o`=0).
- **Reset:**
  - `reset`=1 at any edge forces IDLE and clears `remaining`, the address counter and the in-flight flags.
  - A read in flight at reset does not produce a `load_fifo_we_o`.

## Timing
- **Reset values:**
  - `cmd_ready_o`=1 (IDLE).
  - All of the following are 0: `busy_o`, `done_o`, `mem_re_o`, `mem_we_o`, `load_fifo_we_o`, `store_fifo_re_o`, `mem_addr_o`, `mem_wdata_o`, `data_to_lane_o`.
- Command accepted at edge t: the first `mem_re_o` or `store_fifo_re_o` can be high in cycle t+1.
- **Throughput:** 1 element/cycle when there is no backpressure.
- **Load of N unstalled elements:**
  - `mem_re_o` is high in cycles t+1..t+N.
  - `load_fifo_we_o` is high in cycles t+2..t+N+1.
  - `done_o` is high in cycle t+N+2.
- **Store of N unstalled elements:** same pattern, with `store_fifo_re_o` in place of `mem_re_o` and `mem_we_o` in place of `load_fifo_we_o`.
- **Length 0:** `done_o` is high in cycle t+1 and there is no memory traffic.
- **Stalls:** a stall (almost-full, or empty) inserts bubbles. Each issued read produces exactly one write, exactly 1 cycle later.

## Test plan
- **Unstalled load:** load, base 0x100, len 4, memory returns 0xA0..0xA3.
  - Addresses 0x100, 0x104, 0x108, 0x10C appear on 4 consecutive cycles.
  - `load_fifo_we_o` carries 0xA0..0xA3 one cycle behind.
  - Single `done_o` pulse 2 cycles after the last read.
- **Load backpressure:** load len 8, `load_fifo_almostfull_i` held high for 3 cycles after the 2nd read.
  - No `mem_re_o` during the stall.
  - 8 writes in total, and `load_fifo_full_i` is never violated.
- **Store with gaps:** store, base 0x200, len 3, `store_fifo_empty_i` toggling 0/1 each cycle, lane data 0x11, 0x22, 0x33.
  - `mem_we_o` writes 0x11@0x200, 0x22@0x204, 0x33@0x208, each 1 cycle after its `store_fifo_re_o`.
- **Zero length and clamping:**
  - Len 0: `done_o` at t+1 with no strobes.
  - Len 40: exactly 32 transfers.
- **Address wrap:** base 0xFFFFFFF8, len 4 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- **Reset and commands while busy:**
  - `reset` asserted during the 3rd read of a len-8 load: all outputs are 0 next cycle and `cmd_ready_o`=1.
  - No stray `load_fifo_we_o` follows.
  - A second `cmd_valid_i` during a busy command is ignored.
